// File: rtl/serial_subtractor_8bits_pkg.sv
// Shared constants for the bit-serial subtractor: state encoding and default width.
package sub_pkg;

  localparam int SUB_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_8bits_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// Clock and reset are kept as plain ports on the modules.
import sub_pkg::*;

interface serial_subtractor_8bits_if #(
  parameter int WIDTH = SUB_WIDTH
);

  logic             Sub_start;
  logic [WIDTH-1:0] Sub_in1;
  logic [WIDTH-1:0] Sub_in2;
  logic             Sub_busy;
  logic             Sub_done;
  logic [WIDTH-1:0] Sub_diff;
  logic             Sub_bout;
  logic             Sub_ovf;
  logic             Sub_zero;

  // Requester side: issues operands and start, observes status and results.
  modport master (
    output Sub_start, Sub_in1, Sub_in2,
    input  Sub_busy, Sub_done, Sub_diff, Sub_bout, Sub_ovf, Sub_zero
  );

  // Subtractor side.
  modport slave (
    input  Sub_start, Sub_in1, Sub_in2,
    output Sub_busy, Sub_done, Sub_diff, Sub_bout, Sub_ovf, Sub_zero
  );

endinterface

// File: rtl/serial_subtractor_8bits_full_subtractor.sv
// Single-bit full subtractor cell: in1 - in2 - bin.
module full_subtractor (
  input  logic FS_in1,
  input  logic FS_in2,
  input  logic FS_bin,
  output logic FS_diff,
  output logic FS_bout
);

  assign FS_diff = FS_in1 ^ FS_in2 ^ FS_bin;
  assign FS_bout = (~FS_in1 & FS_in2) | (~(FS_in1 ^ FS_in2) & FS_bin);

endmodule

// File: rtl/serial_subtractor_8bits.sv
// Bit-serial two's-complement subtractor, LSB first, one full-subtractor cell.
//
//   state | meaning
//   IDLE  | waiting for Sub_start; operands captured on the accepting edge
//   RUN   | one bit per clock through the cell, WIDTH edges in total
//   DONE  | one-cycle Sub_done pulse, then back to IDLE
//
// Result outputs only change on the final RUN edge, so the previous result
// stays visible for the whole of a new operation.
import sub_pkg::*;

module serial_subtractor_8bits #(
  parameter int WIDTH = SUB_WIDTH
) (
  input logic                     Sub_clk,
  input logic                     Sub_rst_n,
  serial_subtractor_8bits_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             done_q;

  logic             fs_diff;
  logic             fs_bout;
  logic             last_bit;
  logic [WIDTH-1:0] diff_final;

  full_subtractor u_fs (
    .FS_in1  (a_sr[0]),
    .FS_in2  (b_sr[0]),
    .FS_bin  (borrow),
    .FS_diff (fs_diff),
    .FS_bout (fs_bout)
  );

  // The counter reaches WIDTH-1 just before the last bit is processed.
  assign last_bit   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign diff_final = {fs_diff, r_sr[WIDTH-1:1]};

  // Sequencing, operand/result shift registers and result flag capture.
  // On the last bit a_sr[0]/b_sr[0] hold the original operand MSBs, which
  // is what the overflow test needs.
  always_ff @(posedge Sub_clk or negedge Sub_rst_n) begin
    if (!Sub_rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Sub_start) begin
            a_sr   <= bus.Sub_in1;
            b_sr   <= bus.Sub_in2;
            r_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          r_sr   <= diff_final;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= fs_bout;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            state  <= DONE;
            diff_q <= diff_final;
            bout_q <= fs_bout;
            ovf_q  <= (a_sr[0] != b_sr[0]) && (fs_diff != a_sr[0]);
            zero_q <= (diff_final == '0);
            done_q <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.Sub_busy = (state == RUN);
  assign bus.Sub_done = done_q;
  assign bus.Sub_diff = diff_q;
  assign bus.Sub_bout = bout_q;
  assign bus.Sub_ovf  = ovf_q;
  assign bus.Sub_zero = zero_q;

endmodule
